// File: rtl/qft_amp_mac_pkg.sv
// Shared definitions for the QFT amplitude multiply-accumulate block:
// FSM state encoding, twiddle fraction width and accumulator width.
package qft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  // Twiddles are signed Q1.(TW-2): one sign bit, one integer bit.
  function automatic int frac_of(input int tw);
    return tw - 2;
  endfunction

  // Room for the largest per-beat term (AW+3 bits) summed N_AMP times.
  function automatic int acc_w(input int aw, input int n_amp);
    return aw + 3 + $clog2(n_amp);
  endfunction

endpackage

// File: rtl/qft_amp_mac_if.sv
// Beat input / result output bundle for qft_amp_mac.
// master: frame producer and result consumer; slave: the MAC block.
interface qft_amp_mac_if #(
  parameter int N_AMP = 4,
  parameter int AW    = 8,
  parameter int TW    = 12
);
  localparam int ACC_W = qft_pkg::acc_w(AW, N_AMP);

  logic                    in_valid;
  logic                    in_ready;
  logic                    in_inv;
  logic signed [AW-1:0]    in_r;
  logic signed [AW-1:0]    in_i;
  logic signed [TW-1:0]    in_cos;
  logic signed [TW-1:0]    in_sin;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_r;
  logic signed [ACC_W-1:0] out_i;
  logic                    busy;

  modport master (
    output in_valid, in_inv, in_r, in_i, in_cos, in_sin, out_ready,
    input  in_ready, out_valid, out_r, out_i, busy
  );

  modport slave (
    input  in_valid, in_inv, in_r, in_i, in_cos, in_sin, out_ready,
    output in_ready, out_valid, out_r, out_i, busy
  );

endinterface

// File: rtl/qft_cmul_pipe.sv
// Two-stage complex multiply: S1 registers the four partial products,
// S2 combines them for forward/inverse rotation, drops the twiddle
// fraction bits and sign-extends to the accumulator width.
// Build option: QFT_AMP_MAC_ROUND_EN selects round-half-up instead of floor.
module qft_cmul_pipe import qft_pkg::*; #(
  parameter int AW    = 8,
  parameter int TW    = 12,
  parameter int ACC_W = 13
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic                    in_inv,
  input  logic signed [AW-1:0]    in_r,
  input  logic signed [AW-1:0]    in_i,
  input  logic signed [TW-1:0]    in_cos,
  input  logic signed [TW-1:0]    in_sin,
  output logic                    busy,
  output logic                    res_valid,
  output logic signed [ACC_W-1:0] res_r,
  output logic signed [ACC_W-1:0] res_i
);

  localparam int PW   = AW + TW;
  localparam int SW   = PW + 1;
  localparam int FRAC = frac_of(TW);
  localparam int QW   = SW - FRAC;

  logic                    s1_valid_reg;
  logic                    s1_inv_reg;
  logic                    s2_valid_reg;
  logic signed [ACC_W-1:0] s2_r_reg;
  logic signed [ACC_W-1:0] s2_i_reg;
  logic signed [SW-1:0]    p_rc, p_is, p_rs, p_ic;
  logic signed [SW-1:0]    sum_r, sum_i;
  logic signed [QW-1:0]    q_r, q_i;

  // Product lanes: 0 = r*cos, 1 = i*sin, 2 = r*sin, 3 = i*cos
  for (genvar gi = 0; gi < 4; gi++) begin : g_prod
    logic signed [AW-1:0] a_op;
    logic signed [TW-1:0] b_op;
    logic signed [PW-1:0] prod_reg;

    assign a_op = (gi % 2 == 0) ? in_r : in_i;
    assign b_op = (gi == 0 || gi == 3) ? in_cos : in_sin;

    // S1: capture one partial product per accepted beat
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        prod_reg <= '0;
      else if (in_valid) prod_reg <= PW'(a_op) * PW'(b_op);
    end
  end

  assign p_rc = SW'(g_prod[0].prod_reg);
  assign p_is = SW'(g_prod[1].prod_reg);
  assign p_rs = SW'(g_prod[2].prod_reg);
  assign p_ic = SW'(g_prod[3].prod_reg);

  // S2 combine: subtraction form keeps the most negative twiddle safe
  always_comb begin
    sum_r = p_rc - p_is;
    sum_i = p_rs + p_ic;
    if (s1_inv_reg) begin
      sum_r = p_rc + p_is;
      sum_i = p_ic - p_rs;
    end
  end

`ifdef QFT_AMP_MAC_ROUND_EN
  localparam logic signed [SW-1:0] HALF = SW'(2 ** (FRAC - 1));
  assign q_r = QW'((sum_r + HALF) >>> FRAC);
  assign q_i = QW'((sum_i + HALF) >>> FRAC);
`else
  assign q_r = QW'(sum_r >>> FRAC);
  assign q_i = QW'(sum_i >>> FRAC);
`endif

  // Stage valids and per-beat mode travel with the data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_inv_reg   <= 1'b0;
      s2_valid_reg <= 1'b0;
    end else begin
      s1_valid_reg <= in_valid;
      if (in_valid) s1_inv_reg <= in_inv;
      s2_valid_reg <= s1_valid_reg;
    end
  end

  // S2 result register, sign-extended to the accumulator width
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_r_reg <= '0;
      s2_i_reg <= '0;
    end else if (s1_valid_reg) begin
      s2_r_reg <= ACC_W'(q_r);
      s2_i_reg <= ACC_W'(q_i);
    end
  end

  assign busy      = s1_valid_reg | s2_valid_reg;
  assign res_valid = s2_valid_reg;
  assign res_r     = s2_r_reg;
  assign res_i     = s2_i_reg;

endmodule

// File: rtl/qft_amp_mac.sv
// Streams N_AMP amplitude/twiddle beats per frame, accumulates the complex
// products and presents one QFT coefficient per frame.
// Build option: QFT_AMP_MAC_ROUND_EN (rounding in the multiply pipe).
module qft_amp_mac import qft_pkg::*; #(
  parameter int N_AMP = 4,
  parameter int AW    = 8,
  parameter int TW    = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  qft_amp_mac_if.slave bus
);

  localparam int ACC_W = acc_w(AW, N_AMP);
  localparam int CW    = $clog2(N_AMP);
  localparam logic [CW-1:0] LAST = CW'(N_AMP - 1);

  state_t                  state_reg, state_next;
  logic [CW-1:0]           count_reg, count_next;
  logic                    mode_reg, mode_next;
  logic                    in_ready_reg;
  logic signed [ACC_W-1:0] acc_r_reg, acc_i_reg;
  logic signed [ACC_W-1:0] out_r_reg, out_i_reg;
  logic                    accept;
  logic                    beat_inv;
  logic                    pipe_busy;
  logic                    res_valid;
  logic signed [ACC_W-1:0] res_r, res_i;

  assign accept   = bus.in_valid && in_ready_reg;
  // The first beat uses in_inv directly; later beats use the latched mode
  assign beat_inv = (state_reg == ST_IDLE) ? bus.in_inv : mode_reg;

  qft_cmul_pipe #(
    .AW    (AW),
    .TW    (TW),
    .ACC_W (ACC_W)
  ) u_cmul (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (accept),
    .in_inv    (beat_inv),
    .in_r      (bus.in_r),
    .in_i      (bus.in_i),
    .in_cos    (bus.in_cos),
    .in_sin    (bus.in_sin),
    .busy      (pipe_busy),
    .res_valid (res_valid),
    .res_r     (res_r),
    .res_i     (res_i)
  );

  // Frame sequencing: next state, beat count and frame mode
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    mode_next  = mode_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          mode_next  = bus.in_inv;
          count_next = CW'(1);
          state_next = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          if (count_reg == LAST) begin
            count_next = '0;
            state_next = ST_DRAIN;
          end else begin
            count_next = count_reg + CW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (!pipe_busy) state_next = ST_OUT;
      end
      ST_OUT: begin
        if (bus.out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM registers; in_ready is registered so it is low during reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      count_reg    <= '0;
      mode_reg     <= 1'b0;
      in_ready_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      mode_reg     <= mode_next;
      in_ready_reg <= (state_next == ST_IDLE) || (state_next == ST_ACCUM);
    end
  end

  // S3 accumulate; cleared when the result is taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r_reg <= '0;
      acc_i_reg <= '0;
    end else if (state_reg == ST_OUT && bus.out_ready) begin
      acc_r_reg <= '0;
      acc_i_reg <= '0;
    end else if (res_valid) begin
      acc_r_reg <= acc_r_reg + res_r;
      acc_i_reg <= acc_i_reg + res_i;
    end
  end

  // Output register loaded once the drained sum is final
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r_reg <= '0;
      out_i_reg <= '0;
    end else if (state_reg == ST_DRAIN && state_next == ST_OUT) begin
      out_r_reg <= acc_r_reg;
      out_i_reg <= acc_i_reg;
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = (state_reg == ST_OUT);
  assign bus.out_r     = out_r_reg;
  assign bus.out_i     = out_i_reg;
  assign bus.busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_qft_amp_mac.sv
// Self-checking bench for qft_amp_mac (N_AMP=4, AW=8, TW=12).
module tb_qft_amp_mac;

  localparam int N_AMP = 4;
  localparam int AW    = 8;
  localparam int TW    = 12;
  localparam int N_VEC = 8;

  typedef struct packed {
    logic [3:0][7:0]  ar;
    logic [3:0][7:0]  ai;
    logic [3:0][11:0] tc;
    logic [3:0][11:0] ts;
    logic [3:0]       inv;
    int               er;
    int               ei;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  qft_amp_mac_if #(.N_AMP(N_AMP), .AW(AW), .TW(TW)) bus ();

  qft_amp_mac #(.N_AMP(N_AMP), .AW(AW), .TW(TW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string nm, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic vec_t uni(input int r, input int i, input int c, input int s,
                               input logic [3:0] inv, input int er, input int ei);
    vec_t v;
    for (int k = 0; k < 4; k++) begin
      v.ar[k] = 8'(r);
      v.ai[k] = 8'(i);
      v.tc[k] = 12'(c);
      v.ts[k] = 12'(s);
    end
    v.inv = inv;
    v.er  = er;
    v.ei  = ei;
    return v;
  endfunction

  // Reference: sum over beats of amp * e^{+/-i theta}, each term scaled by 2^-10
  function automatic void model(input vec_t v, output int er, output int ei);
    int sg;
    er = 0;
    ei = 0;
    sg = v.inv[0] ? -1 : 1;
    for (int k = 0; k < 4; k++) begin
      int r, im, c, s, pr, pi;
      r  = $signed(v.ar[k]);
      im = $signed(v.ai[k]);
      c  = $signed(v.tc[k]);
      s  = $signed(v.ts[k]);
      pr = r * c - sg * im * s;
      pi = sg * r * s + im * c;
`ifdef QFT_AMP_MAC_ROUND_EN
      pr = pr + 512;
      pi = pi + 512;
`endif
      er = er + (pr >>> 10);
      ei = ei + (pi >>> 10);
    end
  endfunction

  task automatic send_frame(input vec_t v, input bit gaps);
    for (int k = 0; k < 4; k++) begin
      int t;
      if (gaps) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      t = 0;
      while (!bus.in_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (t >= 50) chk("in_ready_timeout", 0, 1);
      bus.in_valid = 1'b1;
      bus.in_inv   = v.inv[k];
      bus.in_r     = v.ar[k];
      bus.in_i     = v.ai[k];
      bus.in_cos   = v.tc[k];
      bus.in_sin   = v.ts[k];
      @(posedge clk);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  // Called at the negedge after the last accept edge
  task automatic get_result(input string nm, input int er, input int ei, input bit do_hs);
    int edges;
    edges = 0;
    while (!bus.out_valid && edges < 10) begin
      @(posedge clk);
      @(negedge clk);
      edges++;
    end
    chk({nm, "_latency"}, edges, 3);
    chk({nm, "_out_r"}, int'($signed(bus.out_r)), er);
    chk({nm, "_out_i"}, int'($signed(bus.out_i)), ei);
    $display("frame %s: out=(%0d,%0d) expected=(%0d,%0d) latency=%0d",
             nm, $signed(bus.out_r), $signed(bus.out_i), er, ei, edges);
    if (do_hs) begin
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk({nm, "_out_valid_clr"}, int'(bus.out_valid), 0);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_in_ready"}, int'(bus.in_ready), 0);
    chk({nm, "_out_valid"}, int'(bus.out_valid), 0);
    chk({nm, "_busy"}, int'(bus.busy), 0);
    chk({nm, "_out_r"}, int'($signed(bus.out_r)), 0);
    chk({nm, "_out_i"}, int'($signed(bus.out_i)), 0);
  endtask

  vec_t  vecs [N_VEC];
  string names [N_VEC];

  initial begin
    vec_t v;
    int   er, ei;

    bus.in_valid  = 1'b0;
    bus.in_inv    = 1'b0;
    bus.in_r      = '0;
    bus.in_i      = '0;
    bus.in_cos    = '0;
    bus.in_sin    = '0;
    bus.out_ready = 1'b1;

    // Directed table: expected values worked out by hand
    names[0] = "identity";     vecs[0] = uni(1, 0, 1024, 0, 4'b0000, 4, 0);
    names[1] = "cancel";       vecs[1] = uni(10, 0, 0, 0, 4'b0000, 0, 0);
    vecs[1].tc = {12'h000, 12'hC00, 12'h000, 12'h400};
    vecs[1].ts = {12'hC00, 12'h000, 12'h400, 12'h000};
    names[2] = "mode_fwd";     vecs[2] = uni(3, 4, 0, 1024, 4'b0000, -16, 12);
    names[3] = "mode_inv";     vecs[3] = uni(3, 4, 0, 1024, 4'b1111, 16, -12);
    names[4] = "mode_fwd_tog"; vecs[4] = uni(3, 4, 0, 1024, 4'b1010, -16, 12);
    names[5] = "mode_inv_tog"; vecs[5] = uni(3, 4, 0, 1024, 4'b0101, 16, -12);
    names[6] = "extremes";     vecs[6] = uni(-128, -128, -2048, -2048, 4'b0000, 0, 2048);
`ifdef QFT_AMP_MAC_ROUND_EN
    names[7] = "rounding";     vecs[7] = uni(1, 0, 512, 0, 4'b0000, 4, 0);
`else
    names[7] = "rounding";     vecs[7] = uni(1, 0, 512, 0, 4'b0000, 0, 0);
`endif

    // Reset state
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_in_ready", int'(bus.in_ready), 1);
    chk("post_reset_busy", int'(bus.busy), 0);

    // Directed frames, back to back
    for (int n = 0; n < N_VEC; n++) begin
      send_frame(vecs[n], 1'b0);
      get_result(names[n], vecs[n].er, vecs[n].ei, 1'b1);
    end

    // Backpressure: result held 5 cycles, stray beats ignored
    bus.out_ready = 1'b0;
    send_frame(vecs[0], 1'b0);
    get_result("stall", 4, 0, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_r     = 8'sd100;
    bus.in_cos   = 12'sd1000;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_out_r", int'($signed(bus.out_r)), 4);
      chk("stall_out_i", int'($signed(bus.out_i)), 0);
      chk("stall_out_valid", int'(bus.out_valid), 1);
      chk("stall_in_ready", int'(bus.in_ready), 0);
    end
    $display("stall: held 5 cycles out=(%0d,%0d)", $signed(bus.out_r), $signed(bus.out_i));
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("release_out_valid", int'(bus.out_valid), 0);
    chk("release_in_ready", int'(bus.in_ready), 1);
    send_frame(vecs[2], 1'b0);
    get_result("after_stall", -16, 12, 1'b1);

    // Reset after two beats discards the partial frame
    v = uni(50, -70, 2000, -1500, 4'b0000, 0, 0);
    for (int k = 0; k < 2; k++) begin
      bus.in_valid = 1'b1;
      bus.in_r     = v.ar[k];
      bus.in_i     = v.ai[k];
      bus.in_cos   = v.tc[k];
      bus.in_sin   = v.ts[k];
      @(posedge clk);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    $display("midreset: outputs cleared after 2 beats");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midreset_in_ready", int'(bus.in_ready), 1);
    send_frame(vecs[0], 1'b0);
    get_result("post_midreset", 4, 0, 1'b1);

    // Random frames against the reference model
    for (int n = 0; n < 24; n++) begin
      for (int k = 0; k < 4; k++) begin
        v.ar[k] = 8'($urandom);
        v.ai[k] = 8'($urandom);
        v.tc[k] = 12'($urandom);
        v.ts[k] = 12'($urandom);
      end
      v.inv = 4'($urandom);
      if (n < 2) begin
        for (int k = 0; k < 4; k++) begin
          v.ar[k] = 8'h80;
          v.ai[k] = (n == 0) ? 8'h80 : 8'h7F;
          v.tc[k] = 12'h800;
          v.ts[k] = (n == 0) ? 12'h7FF : 12'h800;
        end
      end
      model(v, er, ei);
      send_frame(v, n[0]);
      get_result($sformatf("rand%0d", n), er, ei, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
